// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one memory port between the fetch stage (IFU) and the memory stage
//   (LSU). One master is granted at a time and exactly one transaction is
//   outstanding. The granted request is forwarded to the slave and the slave
//   response is routed back to the same master. The non-granted master always
//   sees req_ready=0, resp_valid=0 and rdata=0.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, a tie in IDLE goes to the master that
//                        was not granted last (first tie after reset -> IFU).
//                        When undefined, a tie always goes to the LSU.
//
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   if_req_*/if_addr            IFU read request (valid/ready handshake)
//   if_resp_*/if_rdata          IFU read response
//   ls_req_*/ls_addr/ls_wen/
//   ls_wdata/ls_wmask           LSU read or write request
//   ls_resp_*/ls_rdata          LSU response (read data or write ack)
//   s_req_*/s_addr/s_wen/
//   s_wdata/s_wmask             request forwarded to the memory slave
//   s_resp_*/s_rdata            response from the memory slave
//   busy                        a transaction is in progress (state != IDLE)
//   grant_ls                    LSU currently owns the port
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    // IFU
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_resp_valid,
    input  logic              if_resp_ready,
    output logic [DATA_W-1:0] if_rdata,
    // LSU
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_wen,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [MASK_W-1:0] ls_wmask,
    output logic              ls_resp_valid,
    input  logic              ls_resp_ready,
    output logic [DATA_W-1:0] ls_rdata,
    // Slave
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wen,
    output logic [DATA_W-1:0] s_wdata,
    output logic [MASK_W-1:0] s_wmask,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [DATA_W-1:0] s_rdata,
    // Status
    output logic              busy,
    output logic              grant_ls
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_LS   = 2'd2
    } gnt_t;

    state_t r_state;
    gnt_t   r_gnt;
    gnt_t   r_last;

    logic w_in_req;
    logic w_in_resp;
    logic w_gnt_if;
    logic w_gnt_ls;
    logic w_any_req;
    logic w_tie_to_ls;
    logic w_pick_ls;
    logic w_req_hs;
    logic w_resp_hs;

    assign w_in_req  = (r_state == ST_REQ);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_gnt_if  = (r_gnt == GNT_IF);
    assign w_gnt_ls  = (r_gnt == GNT_LS);
    assign w_any_req = if_req_valid | ls_req_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // Tie goes to whoever did not win last; last resets to LS so IFU wins first.
    assign w_tie_to_ls = (r_last != GNT_LS);
`else
    // Fixed LSU priority; last is still tracked but plays no part in the choice.
    logic w_unused_last;
    assign w_tie_to_ls   = 1'b1;
    assign w_unused_last = ^r_last;
`endif

    // A lone requester always wins; the tie rule only matters when both ask.
    assign w_pick_ls = ls_req_valid & (~if_req_valid | w_tie_to_ls);

    assign w_req_hs  = s_req_valid & s_req_ready;
    assign w_resp_hs = s_resp_valid & s_resp_ready;

    // Everything below is decoded from registered state, so all outputs are
    // forced to zero the moment resetn asserts and throughout IDLE.
    always_comb begin
        s_req_valid   = 1'b0;
        s_addr        = '0;
        s_wen         = 1'b0;
        s_wdata       = '0;
        s_wmask       = '0;
        s_resp_ready  = 1'b0;
        if_req_ready  = 1'b0;
        ls_req_ready  = 1'b0;
        if_resp_valid = 1'b0;
        ls_resp_valid = 1'b0;
        if_rdata      = '0;
        ls_rdata      = '0;

        if (w_in_req) begin
            if (w_gnt_ls) begin
                s_req_valid  = ls_req_valid;
                s_addr       = ls_addr;
                s_wen        = ls_wen;
                s_wdata      = ls_wdata;
                s_wmask      = ls_wmask;
                ls_req_ready = s_req_ready;
            end else if (w_gnt_if) begin
                // Fetches are always reads: no write enable, no byte mask.
                s_req_valid  = if_req_valid;
                s_addr       = if_addr;
                if_req_ready = s_req_ready;
            end
        end

        if (w_in_resp) begin
            if (w_gnt_ls) begin
                ls_resp_valid = s_resp_valid;
                ls_rdata      = s_rdata;
                s_resp_ready  = ls_resp_ready;
            end else if (w_gnt_if) begin
                if_resp_valid = s_resp_valid;
                if_rdata      = s_rdata;
                s_resp_ready  = if_resp_ready;
            end
        end
    end

    assign busy     = (r_state != ST_IDLE);
    assign grant_ls = w_gnt_ls;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_gnt   <= GNT_NONE;
            r_last  <= GNT_LS;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Grant is decided here and then frozen until the response
                    // handshakes; late arrivals simply wait.
                    if (w_any_req) begin
                        r_gnt   <= w_pick_ls ? GNT_LS : GNT_IF;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A dropped req_valid just parks here with s_req_valid=0.
                    if (w_req_hs) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_hs) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_gnt;
                        r_gnt   <= GNT_NONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= GNT_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Random transactions against a transaction-level model: each round the model
// keeps a set of pending requests, picks the expected winner from the tie
// rules, and predicts what the slave and both masters must see in every phase
// (IDLE, REQ with random slave/master stalls, RESP with random stalls).
// Directed steps then cover a write, reset in the middle of a response and a
// fresh fetch after reset.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 8;

    logic              clk = 1'b0;
    logic              resetn;
    logic              if_req_valid, if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_resp_valid, if_resp_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req_valid, ls_req_ready;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_wen;
    logic [DATA_W-1:0] ls_wdata;
    logic [MASK_W-1:0] ls_wmask;
    logic              ls_resp_valid, ls_resp_ready;
    logic [DATA_W-1:0] ls_rdata;
    logic              s_req_valid, s_req_ready;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wen;
    logic [DATA_W-1:0] s_wdata;
    logic [MASK_W-1:0] s_wmask;
    logic              s_resp_valid, s_resp_ready;
    logic [DATA_W-1:0] s_rdata;
    logic              busy, grant_ls;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MASK_W(MASK_W)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .if_req_valid(if_req_valid),
        .if_req_ready(if_req_ready),
        .if_addr(if_addr),
        .if_resp_valid(if_resp_valid),
        .if_resp_ready(if_resp_ready),
        .if_rdata(if_rdata),
        .ls_req_valid(ls_req_valid),
        .ls_req_ready(ls_req_ready),
        .ls_addr(ls_addr),
        .ls_wen(ls_wen),
        .ls_wdata(ls_wdata),
        .ls_wmask(ls_wmask),
        .ls_resp_valid(ls_resp_valid),
        .ls_resp_ready(ls_resp_ready),
        .ls_rdata(ls_rdata),
        .s_req_valid(s_req_valid),
        .s_req_ready(s_req_ready),
        .s_addr(s_addr),
        .s_wen(s_wen),
        .s_wdata(s_wdata),
        .s_wmask(s_wmask),
        .s_resp_valid(s_resp_valid),
        .s_resp_ready(s_resp_ready),
        .s_rdata(s_rdata),
        .busy(busy),
        .grant_ls(grant_ls)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state: outstanding requests per master and who won last.
    logic        pend_if, pend_ls, last_ls, win_ls, drop;
    logic [31:0] if_a, ls_a, ls_d, rd;
    logic        ls_w;
    logic [7:0]  ls_m;
    int          d_req, d_resp, d_rr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_if();
        pend_if      = 1'b1;
        if_a         = $urandom;
        if_addr      = if_a;
        if_req_valid = 1'b1;
    endtask

    task automatic new_ls();
        pend_ls      = 1'b1;
        ls_a         = $urandom;
        ls_w         = 1'($urandom % 2);
        ls_d         = $urandom;
        ls_m         = 8'($urandom);
        ls_addr      = ls_a;
        ls_wen       = ls_w;
        ls_wdata     = ls_d;
        ls_wmask     = ls_m;
        ls_req_valid = 1'b1;
    endtask

    task automatic set_win_valid(input logic v);
        if (win_ls) ls_req_valid = v;
        else        if_req_valid = v;
    endtask

    // A request from the other master may show up mid-transaction; it must wait.
    task automatic maybe_raise_loser();
        if (win_ls && !pend_if && ($urandom % 2 == 0)) new_if();
        else if (!win_ls && !pend_ls && ($urandom % 2 == 0)) new_ls();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_grant_ls"}, grant_ls, 1'b0);
        chk({tag, "_s_req_valid"}, s_req_valid, 1'b0);
        chk({tag, "_req_ready"}, {if_req_ready, ls_req_ready}, 2'b00);
        chk({tag, "_resp_valid"}, {if_resp_valid, ls_resp_valid}, 2'b00);
        chk({tag, "_s_resp_ready"}, s_resp_ready, 1'b0);
        chk({tag, "_s_addr"}, s_addr, 32'h0);
    endtask

    task automatic chk_req(input logic exp_v, input logic exp_rdy);
        chk("req_busy", busy, 1'b1);
        chk("req_grant_ls", grant_ls, win_ls);
        chk("req_s_req_valid", s_req_valid, exp_v);
        chk("req_win_ready", win_ls ? ls_req_ready : if_req_ready, exp_rdy);
        chk("req_lose_ready", win_ls ? if_req_ready : ls_req_ready, 1'b0);
        chk("req_resp_valid", {if_resp_valid, ls_resp_valid}, 2'b00);
        if (exp_v) begin
            chk("req_s_addr", s_addr, win_ls ? ls_a : if_a);
            chk("req_s_wen", s_wen, win_ls ? ls_w : 1'b0);
            chk("req_s_wmask", s_wmask, win_ls ? ls_m : 8'h00);
            if (win_ls) chk("req_s_wdata", s_wdata, ls_d);
        end
    endtask

    task automatic chk_resp(input logic exp_v, input logic exp_srr);
        chk("resp_busy", busy, 1'b1);
        chk("resp_grant_ls", grant_ls, win_ls);
        chk("resp_s_req_valid", s_req_valid, 1'b0);
        chk("resp_req_ready", {if_req_ready, ls_req_ready}, 2'b00);
        chk("resp_win_valid", win_ls ? ls_resp_valid : if_resp_valid, exp_v);
        chk("resp_lose_valid", win_ls ? if_resp_valid : ls_resp_valid, 1'b0);
        chk("resp_lose_rdata", win_ls ? if_rdata : ls_rdata, 32'h0);
        chk("resp_s_resp_ready", s_resp_ready, exp_srr);
        if (exp_v) chk("resp_win_rdata", win_ls ? ls_rdata : if_rdata, rd);
    endtask

    initial begin
        resetn        = 1'b0;
        if_req_valid  = 1'b1;
        if_addr       = '0;
        if_resp_ready = 1'b0;
        ls_req_valid  = 1'b0;
        ls_addr       = '0;
        ls_wen        = 1'b0;
        ls_wdata      = '0;
        ls_wmask      = '0;
        ls_resp_ready = 1'b0;
        s_req_ready   = 1'b1;
        s_resp_valid  = 1'b0;
        s_rdata       = '0;
        pend_if       = 1'b0;
        pend_ls       = 1'b0;
        last_ls       = 1'b1;
        win_ls        = 1'b0;
        rd            = '0;

        // Held in reset with a request pending: nothing may move.
        #2;
        chk_idle("rst0");
        step();
        step();
        chk_idle("rst1");
        if_req_valid = 1'b0;
        s_req_ready  = 1'b0;
        resetn       = 1'b1;

        for (int t = 0; t < 60; t++) begin
            // IDLE cycle: make sure at least one master is asking.
            if (!pend_if && ($urandom % 2 == 0)) new_if();
            if (!pend_ls && (($urandom % 2 == 0) || !pend_if)) new_ls();
            if (pend_if && pend_ls) begin
`ifdef ARB_ROUND_ROBIN_EN
                win_ls = !last_ls;
`else
                win_ls = 1'b1;
`endif
            end else begin
                win_ls = pend_ls;
            end
            s_req_ready  = 1'($urandom % 2);
            s_resp_valid = 1'b0;
            #1;
            chk_idle("idle");
            step();

            // REQ: random stalls; a stall may also drop the granted valid while
            // the slave is ready, which must not complete the handshake.
            d_req = int'($urandom % 3);
            for (int k = 0; k < d_req; k++) begin
                drop = ($urandom % 4 == 0);
                set_win_valid(!drop);
                s_req_ready = drop;
                maybe_raise_loser();
                #1;
                chk_req(!drop, drop);
                step();
            end
            set_win_valid(1'b1);
            s_req_ready = 1'b1;
            maybe_raise_loser();
            #1;
            chk_req(1'b1, 1'b1);
            step();

            // RESP: the granted master's request is done.
            set_win_valid(1'b0);
            if (win_ls) pend_ls = 1'b0;
            else        pend_if = 1'b0;
            if (win_ls) begin
                ls_resp_ready = 1'b0;
                if_resp_ready = 1'b1;
            end else begin
                if_resp_ready = 1'b0;
                ls_resp_ready = 1'b1;
            end
            d_resp = int'($urandom % 3);
            for (int k = 0; k < d_resp; k++) begin
                #1;
                chk_resp(1'b0, 1'b0);
                step();
            end
            rd           = $urandom;
            s_rdata      = rd;
            s_resp_valid = 1'b1;
            d_rr = int'($urandom % 3);
            for (int k = 0; k < d_rr; k++) begin
                #1;
                chk_resp(1'b1, 1'b0);
                step();
            end
            if (win_ls) ls_resp_ready = 1'b1;
            else        if_resp_ready = 1'b1;
            #1;
            chk_resp(1'b1, 1'b1);
            step();
            s_resp_valid  = 1'b0;
            if_resp_ready = 1'b0;
            ls_resp_ready = 1'b0;
            last_ls       = win_ls;
            $display("txn %0d: winner=%s addr=%08h wen=%0d rdata=%08h pending_if=%0d pending_ls=%0d",
                     t, win_ls ? "LSU" : "IFU", win_ls ? ls_a : if_a,
                     win_ls ? ls_w : 1'b0, rd, pend_if, pend_ls);
        end

        // Quiesce: drop leftover requests during this IDLE cycle.
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        pend_if      = 1'b0;
        pend_ls      = 1'b0;
        s_req_ready  = 1'b1;
        #1;
        chk_idle("quiesce");
        step();

        // LSU write, then reset while the response is stalled.
        win_ls       = 1'b1;
        ls_a         = 32'h8000_1000;
        ls_w         = 1'b1;
        ls_d         = 32'hDEAD_BEEF;
        ls_m         = 8'h0F;
        ls_addr      = ls_a;
        ls_wen       = ls_w;
        ls_wdata     = ls_d;
        ls_wmask     = ls_m;
        ls_req_valid = 1'b1;
        step();
        chk_req(1'b1, 1'b1);
        step();
        ls_req_valid  = 1'b0;
        ls_resp_ready = 1'b0;
        rd            = 32'h1234_5678;
        s_rdata       = rd;
        s_resp_valid  = 1'b1;
        #1;
        chk_resp(1'b1, 1'b0);
        step();
        chk_resp(1'b1, 1'b0);
        ls_resp_ready = 1'b1;
        resetn        = 1'b0;
        #1;
        chk_idle("rst_mid");
        chk("rst_mid_ls_rdata", ls_rdata, 32'h0);
        step();
        resetn       = 1'b1;
        last_ls      = 1'b1;
        s_resp_valid = 1'b0;
        #1;
        chk_idle("after_rst");
        $display("txn dir0: winner=LSU write addr=%08h abandoned by reset", ls_a);

        // Fresh fetch after reset.
        win_ls        = 1'b0;
        if_a          = 32'h8000_0000;
        if_addr       = if_a;
        if_req_valid  = 1'b1;
        if_resp_ready = 1'b1;
        step();
        chk_req(1'b1, 1'b1);
        step();
        if_req_valid = 1'b0;
        rd           = 32'h0000_0413;
        s_rdata      = rd;
        s_resp_valid = 1'b1;
        #1;
        chk_resp(1'b1, 1'b1);
        step();
        s_resp_valid = 1'b0;
        #1;
        chk_idle("fetch_done");
        $display("txn dir1: winner=IFU addr=%08h rdata=%08h", if_a, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
